// File: rtl/avl_dma_rd_master.sv
// Avalon-MM burst read master: splits a (byte address, word length) command into
// bursts and streams every returned word into a downstream FIFO without overrunning it.
module avl_dma_rd_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BW        = 5,
  parameter int LW        = 16,
  parameter int FW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic [BW-1:0] avm_burstcount,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_readdatavalid,
  output logic          fifo_wval,
  output logic [DW-1:0] fifo_wd,
  input  logic          fifo_wrdy,
  input  logic [FW:0]   fifo_cnt,
  output logic          busy,
  output logic          done,
  output logic          ovf_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int CW    = FW + 2;
  localparam int IW    = FW + 1;
  localparam int BYTES = DW / 8;
  localparam logic [LW-1:0] MAXB  = LW'(MAX_BURST);
  localparam logic [CW-1:0] DEPTH = CW'(2 ** FW);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [AW-1:0] avm_addr_q, avm_addr_d;
  logic [BW-1:0] bc_q, bc_d;
  logic          wval_q;
  logic [DW-1:0] wd_q;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [LW-1:0] burst;
  logic [CW-1:0] credit_sum;
  logic          credit_ok;
  logic [LW-1:0] rem_nxt;
  logic          accept;
  logic [IW-1:0] inc, dec;

  // Credit counts the FIFO occupancy plus every word already requested but not yet
  // visible in fifo_cnt, so the return path never needs backpressure.
  always_comb begin
    burst      = (rem_q < MAXB) ? rem_q : MAXB;
    credit_sum = CW'(fifo_cnt) + CW'(inflight_q) + CW'(burst);
    credit_ok  = (credit_sum <= DEPTH);
    rem_nxt    = rem_q - LW'(bc_q);
    accept     = (state_q == S_ISSUE) & ~avm_waitrequest;
    inc        = accept ? IW'(bc_q) : '0;
    dec        = {{(IW-1){1'b0}}, wval_q};
    inflight_d = inflight_q + inc - dec;
    ovf_d      = ovf_q | (wval_q & ~fifo_wrdy);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    avm_addr_d = avm_addr_q;
    bc_d       = bc_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_val && cmd_rdy_q) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (credit_ok) begin
          avm_addr_d = addr_q;
          bc_d       = BW'(burst);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!avm_waitrequest) begin
          addr_d  = addr_q + AW'(bc_q) * AW'(BYTES);
          rem_d   = rem_nxt;
          state_d = (rem_nxt == '0) ? S_DRAIN : S_REQ;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && !wval_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done trails the DONE state by a cycle; cmd_rdy stays low while done is shown.
  always_comb begin
    done_d    = (state_q == S_DONE);
    busy_d    = (state_d != S_IDLE) | done_d;
    cmd_rdy_d = (state_d == S_IDLE) & ~done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      avm_addr_q <= '0;
      bc_q       <= '0;
      wval_q     <= 1'b0;
      wd_q       <= '0;
      cmd_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      avm_addr_q <= avm_addr_d;
      bc_q       <= bc_d;
      wval_q     <= avm_readdatavalid;
      wd_q       <= avm_readdata;
      cmd_rdy_q  <= cmd_rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cmd_rdy        = cmd_rdy_q;
  assign avm_address    = avm_addr_q;
  assign avm_read       = (state_q == S_ISSUE);
  assign avm_burstcount = bc_q;
  assign fifo_wval      = wval_q;
  assign fifo_wd        = wd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_avl_dma_rd_master.sv
// Randomized bench: Avalon slave and FIFO models plus a burst/word reference model
// derived from the command split rules.
module tb_avl_dma_rd_master;
  localparam int AW = 32, DW = 32, BW = 5, LW = 16, FW = 5, MB = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_val, cmd_rdy;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          fifo_wval;
  logic [DW-1:0] fifo_wd;
  logic          fifo_wrdy;
  logic [FW:0]   fifo_cnt;
  logic          busy, done, ovf_err;

  always #5 clk = ~clk;

  avl_dma_rd_master #(.AW(AW), .DW(DW), .BW(BW), .LW(LW), .FW(FW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .fifo_wval(fifo_wval), .fifo_wd(fifo_wd), .fifo_wrdy(fifo_wrdy), .fifo_cnt(fifo_cnt),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  logic [31:0] fifo_q[$];
  logic [31:0] rq[$];
  logic [31:0] exp_b_a[$];
  int          exp_b_c[$];
  logic [31:0] exp_w[$];
  logic [31:0] salt = 32'h1234_5678;
  int  acc_words = 0, wr_words = 0, bursts_seen = 0, done_seen = 0, done_base = 0;
  int  hold_left = 0, stall_seen = 0, ret_budget = -1, drain_budget = 0;
  bit  hold_first = 0, drain_en = 1, rnd_drain = 0, rnd_wait = 0, rnd_ret = 0;
  bit  force_wait = 0, wrdy_low = 0, lossy = 0, ovf_model = 0;
  logic [31:0] hold_a;
  logic [BW-1:0] hold_c;

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Slave + FIFO environment: observe at negedge, drive after posedge.
  initial begin
    bit do_pop;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
    fifo_wrdy = 1; fifo_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fifo_q.delete(); rq.delete(); exp_b_a.delete(); exp_b_c.delete(); exp_w.delete();
        acc_words = 0; wr_words = 0; ovf_model = 0; hold_left = 0;
      end else begin
        chk("ovf_err", ovf_err, ovf_model);
        if (fifo_wval && !fifo_wrdy) ovf_model = 1;
        if (done) done_seen++;
        if (avm_read && avm_waitrequest && hold_left > 0) begin
          if (hold_first) begin
            hold_a = avm_address; hold_c = avm_burstcount; hold_first = 0;
          end else begin
            chk("hold_addr", avm_address, hold_a);
            chk("hold_bc", avm_burstcount, hold_c);
          end
          hold_left--; stall_seen++;
        end
        if (avm_read && !avm_waitrequest) begin
          if (exp_b_a.size() == 0) chk("burst_extra", avm_read, 0);
          else begin
            chk("burst_addr", avm_address, exp_b_a.pop_front());
            chk("burst_cnt", avm_burstcount, exp_b_c.pop_front());
          end
          if (!lossy)
            chk("credit", (fifo_q.size() + acc_words - wr_words + int'(avm_burstcount)) <= DEPTH, 1);
          for (int i = 0; i < int'(avm_burstcount); i++) rq.push_back(avm_address + 32'(4 * i));
          acc_words += int'(avm_burstcount);
          bursts_seen++;
        end
        do_pop = 0;
        if (fifo_q.size() > 0) begin
          if (drain_budget > 0) begin do_pop = 1; drain_budget--; end
          else if (drain_en && (!rnd_drain || $urandom_range(0, 2) != 0)) do_pop = 1;
        end
        if (do_pop) void'(fifo_q.pop_front());
        if (fifo_wval && fifo_wrdy) begin
          fifo_q.push_back(fifo_wd);
          wr_words++;
          if (!lossy) begin
            if (exp_w.size() == 0) chk("word_extra", fifo_wval, 0);
            else chk("word", fifo_wd, exp_w.pop_front());
          end
        end
      end
      @(posedge clk); #1;
      avm_readdatavalid = 0;
      if (!rst_n) begin
        avm_waitrequest = 0; fifo_cnt = '0; fifo_wrdy = 1;
      end else begin
        fifo_cnt  = 6'(fifo_q.size());
        fifo_wrdy = !wrdy_low && (fifo_q.size() < DEPTH);
        avm_waitrequest = force_wait || (hold_left > 0) || (rnd_wait && $urandom_range(0, 3) == 0);
        if (rq.size() > 0 && ret_budget != 0 && (!rnd_ret || $urandom_range(0, 3) != 0)) begin
          avm_readdatavalid = 1;
          avm_readdata = wdata(rq.pop_front());
          if (ret_budget > 0) ret_budget--;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int len);
    logic [31:0] p;
    int r, b, n;
    salt = $urandom;
    p = a; r = len;
    while (r > 0) begin
      b = (r < MB) ? r : MB;
      exp_b_a.push_back(p); exp_b_c.push_back(b);
      for (int i = 0; i < b; i++) exp_w.push_back(wdata(p + 32'(4 * i)));
      p = p + 32'(4 * b);
      r -= b;
    end
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
    chk("cmd_rdy_to", cmd_rdy, 1);
    done_base = done_seen;
    cmd_val = 1; cmd_addr = a; cmd_len = 16'(len);
    @(posedge clk); #1;
    cmd_val = 0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_seen == done_base && n < bound) begin @(negedge clk); n++; end
    chk("done_to", done_seen > done_base, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_seen - done_base, 1);
    chk("bursts_left", exp_b_a.size(), 0);
    if (!lossy) chk("words_left", exp_w.size(), 0);
    else exp_w.delete();
    chk("busy_end", busy, 0);
  endtask

  task automatic rst_vals(input string p);
    chk({p, "_rdy"}, cmd_rdy, 0);
    chk({p, "_read"}, avm_read, 0);
    chk({p, "_addr"}, avm_address, 0);
    chk({p, "_bc"}, avm_burstcount, 0);
    chk({p, "_wval"}, fifo_wval, 0);
    chk({p, "_wd"}, fifo_wd, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_ovf"}, ovf_err, 0);
  endtask

  initial begin
    int b0, w0, n;
    cmd_val = 0; cmd_addr = '0; cmd_len = '0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_vals("rst");
    #2 rst_n = 1;
    @(negedge clk);
    chk("rdy_after_rst", cmd_rdy, 1);

    // 40 words from 0x1000: 16,16,8
    send_cmd(32'h1000, 40);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_read_early", avm_read, 0);
    @(negedge clk);
    chk("t1_read", avm_read, 1);
    chk("t1_addr", avm_address, 32'h1000);
    chk("t1_bc", avm_burstcount, 16);
    wait_done(500);

    // zero length
    b0 = bursts_seen;
    send_cmd(32'h2000, 0);
    @(negedge clk);
    chk("zl_busy1", busy, 1); chk("zl_done1", done, 0); chk("zl_read1", avm_read, 0);
    @(negedge clk);
    chk("zl_busy2", busy, 1); chk("zl_done2", done, 1); chk("zl_rdy2", cmd_rdy, 0);
    @(negedge clk);
    chk("zl_busy3", busy, 0); chk("zl_done3", done, 0); chk("zl_rdy3", cmd_rdy, 1);
    chk("zl_bursts", bursts_seen - b0, 0);
    wait_done(20);

    // FIFO not drained: two bursts fill it, third waits for 16 free slots
    drain_en = 0;
    b0 = bursts_seen;
    send_cmd(32'h2000, 64);
    n = 0;
    while (fifo_q.size() < DEPTH && n < 600) begin @(negedge clk); n++; end
    chk("fill_to", fifo_q.size(), DEPTH);
    repeat (10) @(negedge clk);
    chk("stall_bursts", bursts_seen - b0, 2);
    chk("stall_read", avm_read, 0);
    chk("stall_cnt", fifo_cnt, 32);
    drain_budget = 16;
    n = 0;
    while (bursts_seen - b0 < 3 && n < 100) begin @(negedge clk); n++; end
    chk("release", bursts_seen - b0, 3);
    drain_en = 1;
    wait_done(1000);

    // waitrequest held for 5 cycles on the first burst
    hold_left = 5; hold_first = 1; stall_seen = 0;
    send_cmd(32'h3000, 20);
    wait_done(500);
    chk("stalls", stall_seen, 5);

    // address wrap
    send_cmd(32'hFFFF_FFC0, 40);
    wait_done(500);

    // randomized commands
    rnd_wait = 1; rnd_ret = 1; rnd_drain = 1;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      send_cmd(a, $urandom_range(0, 90));
      wait_done(4000);
    end
    rnd_wait = 0; rnd_ret = 0; rnd_drain = 0;

    // reset while the second burst is stalled in ISSUE with 12 words in flight
    ret_budget = 4;
    b0 = bursts_seen; w0 = wr_words;
    send_cmd(32'h4000, 32);
    n = 0;
    while (bursts_seen == b0 && n < 50) begin @(negedge clk); n++; end
    force_wait = 1;
    n = 0;
    while (!(wr_words - w0 == 4 && avm_read) && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("pre_rst_read", avm_read, 1);
    chk("pre_rst_words", wr_words - w0, 4);
    #3 rst_n = 0;
    #1 rst_vals("arst");
    repeat (2) @(negedge clk);
    force_wait = 0; ret_budget = -1;
    #2 rst_n = 1;
    send_cmd(32'h5000, 4);
    wait_done(200);

    // overflow: return data while FIFO reports not ready
    lossy = 1; wrdy_low = 1;
    send_cmd(32'h6000, 8);
    wait_done(200);
    chk("ovf_set", ovf_err, 1);
    wrdy_low = 0;
    repeat (5) @(negedge clk);
    chk("ovf_sticky", ovf_err, 1);
    #2 rst_n = 0;
    #1 chk("ovf_rst", ovf_err, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    lossy = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
